// File: rtl/dm_store_buffer_pkg.sv
// Shared CPU memory-op encodings: store ops used by the store buffer and
// the load-extension ops used by the load path, kept together so both
// decoders agree on one definition.
package dm_store_buffer_pkg;

  // Store type carried on req_op
  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } st_op_e;

  // Load-extension op codes (sign/zero extension selection on the load path)
  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } ld_op_e;

endpackage

// File: rtl/dm_store_buffer_store_lane_gen.sv
// store_lane_gen: combinational mapping of store op, low address bits and
// register data to byte enables and lane-replicated write data.
// Optional macro STORE_ALIGN_CHECK_EN: when defined, o_misaligned flags an
// SH with A[0]=1 or an SW with A!=00; otherwise o_misaligned is always 0.
module store_lane_gen
  import dm_store_buffer_pkg::*;
(
  input  logic [1:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_reserved,
  output logic        o_misaligned
);

  // Decode the op into byte enables, replicated data and drop flags
  always_comb begin
    o_be         = 4'b0000;
    o_wdata      = 32'h0;
    o_reserved   = 1'b0;
    o_misaligned = 1'b0;
    case (st_op_e'(i_op))
      ST_SW: begin
        o_be    = 4'b1111;
        o_wdata = i_data;
`ifdef STORE_ALIGN_CHECK_EN
        o_misaligned = (i_addr_lo != 2'b00);
`endif
      end
      ST_SH: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_data[15:0]}};
`ifdef STORE_ALIGN_CHECK_EN
        o_misaligned = i_addr_lo[0];
`endif
      end
      ST_SB: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_data[7:0]}};
      end
      default: begin
        o_reserved = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dm_store_buffer.sv
// dm_store_buffer: DEPTH-entry circular store buffer between the CPU store
// path and data memory. Lane formatting happens at enqueue so the memory
// side is driven purely from head-entry registers.
// Optional macro STORE_ALIGN_CHECK_EN: drops misaligned SW/SH and raises a
// one-cycle exc_ades pulse with the offending address.
module dm_store_buffer
  import dm_store_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_data,
  input  logic [1:0]               req_op,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     exc_ades,
  output logic [31:0]              exc_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [29:0]   r_ent_addr  [DEPTH];
  logic [31:0]   r_ent_wdata [DEPTH];
  logic [3:0]    r_ent_be    [DEPTH];

  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_reserved;
  logic          w_misaligned;
  logic          w_full;
  logic          w_empty;
  logic          w_fire;
  logic          w_push;
  logic          w_pop;

  store_lane_gen u_lane (
    .i_op         (req_op),
    .i_addr_lo    (req_addr[1:0]),
    .i_data       (req_data),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_reserved   (w_reserved),
    .o_misaligned (w_misaligned)
  );

  // Full blocks new requests even if the head pops this cycle (no bypass)
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign req_ready = ~w_full;
  assign mem_valid = ~w_empty;

  // Reserved and (when checked) misaligned requests are consumed but dropped
  assign w_fire = req_valid & req_ready;
  assign w_push = w_fire & ~w_reserved & ~w_misaligned;
  assign w_pop  = mem_valid & mem_ready;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // One register slot per entry, written when the write pointer selects it
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Capture the formatted store into this slot on push
      always_ff @(posedge clk) begin
        if (w_push && (r_wr_ptr == PW'(gi))) begin
          r_ent_addr[gi]  <= req_addr[31:2];
          r_ent_wdata[gi] <= w_wdata;
          r_ent_be[gi]    <= w_be;
        end
      end
    end
  endgenerate

  // Head outputs come from registers only; forced to zero when nothing is
  // queued so reset and idle present a clean bus
  assign mem_addr  = w_empty ? 32'h0 : {r_ent_addr[r_rd_ptr], 2'b00};
  assign mem_wdata = w_empty ? 32'h0 : r_ent_wdata[r_rd_ptr];
  assign mem_be    = w_empty ? 4'b0000 : r_ent_be[r_rd_ptr];
  assign count     = r_count;

`ifdef STORE_ALIGN_CHECK_EN
  logic        r_exc_ades;
  logic [31:0] r_exc_addr;

  // Pulse the misaligned-store exception on the edge after acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exc_ades <= 1'b0;
      r_exc_addr <= 32'h0;
    end else begin
      r_exc_ades <= w_fire & w_misaligned;
      r_exc_addr <= (w_fire & w_misaligned) ? req_addr : 32'h0;
    end
  end

  assign exc_ades = r_exc_ades;
  assign exc_addr = r_exc_addr;
`else
  assign exc_ades = 1'b0;
  assign exc_addr = 32'h0;
`endif

endmodule
